uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface

- REQ-001 SHALL have parameter NBITS_DATA, default 8: number of data bits per frame.
- REQ-002 SHALL have parameter OVERSAMPLE, default 16: baud ticks per data/start bit. Must be even and ≥ 4.
- REQ-003 SHALL have parameter STOPBITS_TCK, default 16: baud ticks sampled in the stop bit.
- REQ-004 SHALL have port i_clk, input, 1 bit: single clock. All state updates occur on its rising edge.
- REQ-005 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 SHALL have port i_rx, input, 1 bit: asynchronous serial line. Idle level is 1.
- REQ-007 SHALL have port i_tick_brg, input, 1 bit: baud-rate-generator tick. One-cycle pulse at OVERSAMPLE × baud rate.
- REQ-008 SHALL have port o_data, output, NBITS_DATA bits: last correctly received word.
- REQ-009 SHALL have port o_rx_done, output, 1 bit: one-cycle pulse when o_data has been updated.
- REQ-010 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.

Function

- REQ-011 SHALL pass i_rx through a 2-flop synchronizer.
  - Both flops reset to 1.
  - All decisions use the synchronized value (rx_s).
- REQ-012 SHALL implement a registered FSM with states IDLE, START, DATA, STOP, plus these registers:
  - tick counter, width ≥ clog2(max(OVERSAMPLE, STOPBITS_TCK));
  - bit counter, width ≥ clog2(NBITS_DATA);
  - shift register, NBITS_DATA bits.
- REQ-013 In IDLE, when rx_s==0, SHALL go to START with tick counter cleared. Ticks are ignored in IDLE.
- REQ-014 In START, SHALL count only cycles with i_tick_brg=1. No other cycle advances any counter.
- REQ-015 In START, on the tick where the counter equals OVERSAMPLE/2−1 (the start-bit midpoint):
  - if rx_s==0, go to DATA with tick counter and bit counter cleared;
  - if rx_s==1, treat it as a glitch and return to IDLE with no output pulse.
- REQ-016 In DATA, on the tick where the counter equals OVERSAMPLE−1 (the bit midpoint), SHALL:
  - shift rx_s into the MSB of the shift register, shifting right (LSB-first line order);
  - clear the tick counter;
  - go to STOP if the bit counter equals NBITS_DATA−1, otherwise increment the bit counter.
- REQ-017 In STOP, on the tick where the counter equals STOPBITS_TCK−1:
  - go to IDLE;
  - if rx_s==1, load o_data from the shift register and assert o_rx_done in the following cycle;
  - if rx_s==0, assert o_frame_err in the following cycle and leave o_data unchanged.
- REQ-018 o_rx_done and o_frame_err SHALL be registered, high for exactly one i_clk cycle, and never high simultaneously.
- REQ-019 o_data SHALL hold its value between frames and change only in the cycle o_rx_done rises.
- REQ-020 After STOP returns to IDLE, a new start edge SHALL be accepted with no dead cycles, so back-to-back frames are received without loss.
- REQ-021 A frame whose stop bit is 0 SHALL still return to IDLE. If the line stays low, it SHALL be treated as a new start bit in the next cycle.
- REQ-022 Latency from the synchronized midpoint tick of the stop bit to the o_rx_done rising edge SHALL be exactly 1 i_clk cycle.

Reset

- REQ-023 While i_reset=0, the block SHALL be in this state, immediately and independently of i_clk:
  - state = IDLE;
  - all counters = 0;
  - shift register = 0;
  - o_data = 0;
  - o_rx_done = 0, o_frame_err = 0;
  - synchronizer flops = 1.
- REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no output pulse.
- REQ-025 After i_reset deasserts, the block SHALL wait in IDLE for a fresh falling edge of rx_s.

Verification

- REQ-026 Nominal frame: defaults, tick every 10 clk, send 0xA5 as start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 160 clk → one o_rx_done pulse, o_data=0xA5, o_frame_err never 1.
- REQ-027 Glitch: i_rx low for 40 clk (4 ticks) then high → state returns to IDLE, no pulse, o_data unchanged.
- REQ-028 Framing error: send 0x3C with stop bit held 0 → one o_frame_err pulse, no o_rx_done, o_data keeps its prior value.
- REQ-029 Back-to-back: 0x00, 0xFF, 0x81 with no idle gap → three o_rx_done pulses, o_data values 0x00, 0xFF, 0x81 in order.
- REQ-030 Reset mid-frame: assert i_reset after the 4th data bit of 0x55, release, then send 0x12 → no pulse for the aborted frame, single o_rx_done with o_data=0x12.
- REQ-031 Tick gating: hold i_tick_brg=0 for 1000 clk during DATA → counters and state frozen, and reception completes correctly once ticks resume.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, oversampled start/data/stop
// sampling driven by an external baud-rate tick.
module uart_rx #(
  parameter int NBITS_DATA   = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int STOPBITS_TCK = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx,
  input  logic                  i_tick_brg,
  output logic [NBITS_DATA-1:0] o_data,
  output logic                  o_rx_done,
  output logic                  o_frame_err
);

  localparam int TMAX = (OVERSAMPLE > STOPBITS_TCK)
                      ? OVERSAMPLE : STOPBITS_TCK;
  localparam int TW = $clog2(TMAX);
  localparam int BW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(STOPBITS_TCK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBITS_DATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state;
  logic [TW-1:0]           tick_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [NBITS_DATA-1:0]   shreg;
  logic                    rx_meta;
  logic                    rx_s;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (i_tick_brg) begin
            if (tick_cnt == T_MID) begin
              if (!rx_s) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_tick_brg) begin
            if (tick_cnt == T_BIT) begin
              // LSB arrives first, so new bits enter at the MSB
              shreg    <= NBITS_DATA'({rx_s, shreg} >> 1);
              tick_cnt <= '0;
              if (bit_cnt == B_LAST) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_tick_brg) begin
            if (tick_cnt == T_STOP) begin
              state <= IDLE;
              if (rx_s) begin
                o_data    <= shreg;
                o_rx_done <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random
// frames scored against a frame-level reference model.
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_tick_brg;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;

  int checks   = 0;
  int failures = 0;

  bit tick_en = 1'b1;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  int           exp_ferr = 0;
  int           ferr_cnt = 0;
  logic [7:0]   last_data = 8'h00;

  uart_rx dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .i_tick_brg  (i_tick_brg),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  // one tick every 10 clk; pausing freezes the phase too
  initial begin
    int c;
    c = 0;
    i_tick_brg = 1'b0;
    forever begin
      @(negedge i_clk);
      if (tick_en) begin
        c++;
        if (c == 10) begin
          c = 0;
          i_tick_brg = 1'b1;
        end else begin
          i_tick_brg = 1'b0;
        end
      end else begin
        i_tick_brg = 1'b0;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // output monitor
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_rst  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge i_clk) begin
    if (o_rx_done) begin
      got_q.push_back(o_data);
      chk("done_excl", {30'd0, prev_done, o_frame_err}, 0);
    end
    if (o_frame_err) begin
      ferr_cnt++;
      chk("ferr_width", {31'd0, prev_ferr}, 0);
    end
    if (i_reset && prev_rst && (o_data !== prev_data))
      chk("data_chg_w_done", {31'd0, o_rx_done}, 1);
    prev_done <= o_rx_done;
    prev_ferr <= o_frame_err;
    prev_rst  <= i_reset;
    prev_data <= o_data;
  end

  task automatic idle(int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic drive_bit(logic v, int n, int pause_at);
    i_rx = v;
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        tick_en = 1'b0;
        idle(1000);
        chk("gate_quiet_done", got_q.size(), 0);
        chk("gate_quiet_ferr", ferr_cnt, 0);
        tick_en = 1'b1;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic send(logic [7:0] b, logic stop,
                      int stop_len, int gate_bit);
    drive_bit(1'b0, 160, -1);
    for (int i = 0; i < 8; i++)
      drive_bit(b[i], 160, (i == gate_bit) ? 80 : -1);
    drive_bit(stop, stop_len, -1);
    i_rx = 1'b1;
    if (stop) begin
      exp_q.push_back(b);
      last_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic compare(string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size()
                                      : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_odata"}, o_data, last_data);
    got_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
    exp_ferr = 0;
  endtask

  initial begin
    logic [7:0] b;
    logic       st;
    logic [7:0] p;

    i_reset = 1'b0;
    i_rx    = 1'b1;
    idle(5);
    chk("rst_data", o_data, 0);
    chk("rst_done", o_rx_done, 0);
    chk("rst_ferr", o_frame_err, 0);
    i_reset = 1'b1;
    idle(20);

    send(8'hA5, 1'b1, 160, -1);
    idle(100);
    compare("nominal");

    i_rx = 1'b0;
    idle(40);
    i_rx = 1'b1;
    idle(300);
    compare("glitch");

    // short low stop: sampled low, then the line returns high
    send(8'h3C, 1'b0, 110, -1);
    idle(300);
    compare("framing");

    send(8'h00, 1'b1, 160, -1);
    send(8'hFF, 1'b1, 160, -1);
    send(8'h81, 1'b1, 160, -1);
    idle(100);
    compare("b2b");

    p = 8'h55;
    drive_bit(1'b0, 160, -1);
    for (int i = 0; i < 4; i++)
      drive_bit(p[i], 160, -1);
    i_reset = 1'b0;
    idle(3);
    chk("rst_mid_data", o_data, 0);
    last_data = 8'h00;
    i_rx = 1'b1;
    idle(10);
    i_reset = 1'b1;
    idle(200);
    send(8'h12, 1'b1, 160, -1);
    idle(100);
    compare("reset_mid");

    send(8'h6B, 1'b1, 160, 3);
    idle(100);
    compare("gating");

    for (int k = 0; k < 8; k++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      if (st) begin
        send(b, 1'b1, 160, -1);
        idle($urandom_range(0, 200));
      end else begin
        send(b, 1'b0, 110, -1);
        idle(300);
      end
    end
    idle(100);
    compare("random");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
